// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice, LSB first.
// Subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             overflow,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_ovf;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_ld;
  logic             w_c0;
  logic             w_sum;
  logic             w_cy;
  logic             w_last;

`ifdef SERIAL_ADD_SUB_EN
  assign w_b_ld = ctrl_sub ? ~data_operandB : data_operandB;
  assign w_c0   = ctrl_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = ctrl_sub;
  assign w_b_ld = data_operandB;
  assign w_c0   = 1'b0;
`endif

  assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cy   = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Handshake outputs depend only on state (and reset holding off accepts).
  assign in_ready    = (r_state == IDLE) & ~reset;
  assign out_valid   = (r_state == DONE);
  assign data_result = r_res;
  assign overflow    = r_ovf;
  assign carry_out   = r_cout;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= data_operandA;
            r_b     <= w_b_ld;
            r_carry <= w_c0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cy;
          r_cnt   <= r_cnt + CW'(1);
          // First edge starts a fresh result; old one stays visible until now.
          if (r_cnt == '0)
            r_res <= {w_sum, {(WIDTH-1){1'b0}}};
          else
            r_res <= {w_sum, r_res[WIDTH-1:1]};
          if (w_last) begin
            r_cout <= w_cy;
            r_ovf  <= r_carry ^ w_cy;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
